// File: rtl/gsim_x_collector_if.sv
// Solver-to-consumer bus of the x collector: input frame stream, drained word stream, status pulses.
interface gsim_x_collector_if;
    logic        in_valid;
    logic [31:0] in_data;
    logic        o_valid;
    logic        o_ready;
    logic [15:0] o_data;
    logic [3:0]  o_idx;
    logic        o_last;
    logic        frame_drop;
    logic        short_frame;

    modport master (
        output in_valid, in_data, o_ready,
        input  o_valid, o_data, o_idx, o_last, frame_drop, short_frame
    );

    modport slave (
        input  in_valid, in_data, o_ready,
        output o_valid, o_data, o_idx, o_last, frame_drop, short_frame
    );
endinterface

// File: rtl/gsim_x_collector.sv
// Ping-pong capture of Q16.16 solution frames, drained as rounded/saturated int16 words
// over valid/ready without ever stalling the solver.
module gsim_x_collector #(
    parameter int unsigned N     = 16,
    parameter int unsigned ROUND = 1
) (
    input logic              clk,
    input logic              reset,
    gsim_x_collector_if.slave bus
);
    localparam int unsigned IW       = $clog2(N);
    localparam logic [3:0]  LAST_IDX = 4'(N - 1);
    localparam logic [32:0] RND_ADD  = (ROUND != 0) ? 33'h0_0000_8000 : 33'h0;

    typedef enum logic [1:0] {B_FREE, B_FILLING, B_FULL} bank_t;
    typedef enum logic [1:0] {C_IDLE, C_FILL, C_SKIP}    cap_state_t;
    typedef enum logic       {D_IDLE, D_SEND}            drn_state_t;

    cap_state_t  c_state, c_state_n;
    drn_state_t  d_state, d_state_n;
    bank_t       bank_st [0:1];
    logic [31:0] mem [0:1][0:N-1];

    logic        wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
    logic [3:0]  wr_idx, wr_idx_n;
    logic        wr_en_c, cap_fill_c, cap_full_c, cap_free_c, drain_free_c;
    logic        frame_drop_q, frame_drop_n, short_frame_q, short_frame_n;
    logic        o_valid_q, o_valid_n, o_last_q, o_last_n;
    logic [15:0] o_data_q, o_data_n;
    logic [3:0]  o_idx_q, o_idx_n;

    logic [3:0]  rd_sel_c;
    logic [31:0] rd_word_c;
    logic [32:0] rd_sum_c;
    logic [15:0] rd_conv_c;
    logic        unused_frac;

    // Round/saturate the word the drain is about to present.
    assign rd_sel_c    = (d_state == D_SEND) ? o_idx_q + 4'd1 : 4'd0;
    assign rd_word_c   = mem[rd_ptr][rd_sel_c[IW-1:0]];
    assign rd_sum_c    = {rd_word_c[31], rd_word_c} + RND_ADD;
    assign rd_conv_c   = (rd_sum_c[32] != rd_sum_c[31]) ? 16'h7FFF : rd_sum_c[31:16];
    assign unused_frac = ^rd_sum_c[15:0];

    // Capture FSM: bank availability is judged on the registered bank state only.
    always_comb begin
        c_state_n     = c_state;
        wr_ptr_n      = wr_ptr;
        wr_idx_n      = wr_idx;
        wr_en_c       = 1'b0;
        cap_fill_c    = 1'b0;
        cap_full_c    = 1'b0;
        cap_free_c    = 1'b0;
        frame_drop_n  = 1'b0;
        short_frame_n = 1'b0;
        case (c_state)
            C_IDLE: begin
                if (bus.in_valid) begin
                    if (bank_st[wr_ptr] == B_FREE) begin
                        wr_en_c    = 1'b1;
                        cap_fill_c = 1'b1;
                        wr_idx_n   = 4'd1;
                        c_state_n  = C_FILL;
                    end else begin
                        frame_drop_n = 1'b1;
                        c_state_n    = C_SKIP;
                    end
                end
            end
            C_FILL: begin
                if (bus.in_valid) begin
                    wr_en_c = 1'b1;
                    if (wr_idx == LAST_IDX) begin
                        cap_full_c = 1'b1;
                        wr_ptr_n   = ~wr_ptr;
                        wr_idx_n   = 4'd0;
                        c_state_n  = C_SKIP;
                    end else begin
                        wr_idx_n = wr_idx + 4'd1;
                    end
                end else begin
                    cap_free_c    = 1'b1;
                    short_frame_n = 1'b1;
                    wr_idx_n      = 4'd0;
                    c_state_n     = C_IDLE;
                end
            end
            C_SKIP: begin
                if (!bus.in_valid) begin
                    c_state_n = C_IDLE;
                end
            end
            default: c_state_n = C_IDLE;
        endcase
    end

    // Drain FSM: output register only moves on a handshake.
    always_comb begin
        d_state_n    = d_state;
        rd_ptr_n     = rd_ptr;
        drain_free_c = 1'b0;
        o_valid_n    = o_valid_q;
        o_data_n     = o_data_q;
        o_idx_n      = o_idx_q;
        o_last_n     = o_last_q;
        case (d_state)
            D_IDLE: begin
                if (bank_st[rd_ptr] == B_FULL) begin
                    o_valid_n = 1'b1;
                    o_data_n  = rd_conv_c;
                    o_idx_n   = 4'd0;
                    o_last_n  = (LAST_IDX == 4'd0);
                    d_state_n = D_SEND;
                end
            end
            D_SEND: begin
                if (o_valid_q && bus.o_ready) begin
                    if (o_last_q) begin
                        o_valid_n    = 1'b0;
                        o_last_n     = 1'b0;
                        drain_free_c = 1'b1;
                        rd_ptr_n     = ~rd_ptr;
                        d_state_n    = D_IDLE;
                    end else begin
                        o_data_n = rd_conv_c;
                        o_idx_n  = o_idx_q + 4'd1;
                        o_last_n = ((o_idx_q + 4'd1) == LAST_IDX);
                    end
                end
            end
            default: d_state_n = D_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            c_state       <= C_IDLE;
            d_state       <= D_IDLE;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            wr_idx        <= 4'd0;
            frame_drop_q  <= 1'b0;
            short_frame_q <= 1'b0;
            o_valid_q     <= 1'b0;
            o_data_q      <= 16'd0;
            o_idx_q       <= 4'd0;
            o_last_q      <= 1'b0;
        end else begin
            c_state       <= c_state_n;
            d_state       <= d_state_n;
            wr_ptr        <= wr_ptr_n;
            rd_ptr        <= rd_ptr_n;
            wr_idx        <= wr_idx_n;
            frame_drop_q  <= frame_drop_n;
            short_frame_q <= short_frame_n;
            o_valid_q     <= o_valid_n;
            o_data_q      <= o_data_n;
            o_idx_q       <= o_idx_n;
            o_last_q      <= o_last_n;
        end
    end

    // Capture and drain always touch different banks, so both updates may land together.
    always_ff @(posedge clk) begin
        if (reset) begin
            bank_st[0] <= B_FREE;
            bank_st[1] <= B_FREE;
        end else begin
            if (cap_fill_c)   bank_st[wr_ptr] <= B_FILLING;
            if (cap_full_c)   bank_st[wr_ptr] <= B_FULL;
            if (cap_free_c)   bank_st[wr_ptr] <= B_FREE;
            if (drain_free_c) bank_st[rd_ptr] <= B_FREE;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_ptr][wr_idx[IW-1:0]] <= bus.in_data;
        end
    end

    assign bus.o_valid     = o_valid_q;
    assign bus.o_data      = o_data_q;
    assign bus.o_idx       = o_idx_q;
    assign bus.o_last      = o_last_q;
    assign bus.frame_drop  = frame_drop_q;
    assign bus.short_frame = short_frame_q;
endmodule
